// File: rtl/cartoon_pkg.sv
// Shared types and defaults for the cartoon read buffer.
package cartoon_pkg;
  localparam int PIXEL_W_DEF    = 24;
  localparam int BANK_DEPTH_DEF = 6;
  localparam int CNT_W          = 20;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } read_state_t;
endpackage

// File: rtl/read_buffer_if.sv
// Avalon-MM read master bus bundle used by read_buffer.
interface read_buffer_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] master_address;
  logic              master_read;
  logic              master_waitrequest;
  logic [31:0]       master_readdata;
  logic              master_readdatavalid;

  modport master (
    output master_address, master_read,
    input  master_waitrequest, master_readdata, master_readdatavalid
  );

  modport slave (
    input  master_address, master_read,
    output master_waitrequest, master_readdata, master_readdatavalid
  );
endinterface

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear and count enable.
module flex_counter #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count <= '0;
    else if (clear) count <= '0;
    else if (en)    count <= count + WIDTH'(1);
  end
endmodule

// File: rtl/read_buffer.sv
// Ping-pong bank frame reader: Avalon-MM reads in, pixel stream out.
// Define READ_BUFFER_STATS_EN to add the stall_count statistics output.
module read_buffer
  import cartoon_pkg::*;
#(
  parameter int PIXEL_W    = PIXEL_W_DEF,
  parameter int BANK_DEPTH = BANK_DEPTH_DEF,
  parameter int ADDR_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_address,
  input  logic [CNT_W-1:0]   total_pixels,
  read_buffer_if.master      bus,
  output logic [PIXEL_W-1:0] pixel_data,
  output logic               pixel_valid,
  input  logic               pixel_ready,
  output logic               done_read
`ifdef READ_BUFFER_STATS_EN
  ,
  output logic [15:0]        stall_count
`endif
);
  localparam int FILL_W = $clog2(BANK_DEPTH + 1);
  localparam int IDX_W  = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam int SUM_W  = CNT_W + 1;

  read_state_t       state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  total, req_cnt, rsp_cnt;
  logic              fill_sel;
  logic [FILL_W-1:0] fill_cnt, drain_left;
  logic [IDX_W-1:0]  drain_idx;
  logic [PIXEL_W-1:0] bank [2][BANK_DEPTH];

  logic             start_go, busy, issue, accept, rsp_fire, xfer;
  logic             fill_ready, drain_empty, swap, last_xfer;
  logic [SUM_W-1:0] in_flight;
  logic             unused_readdata;

  assign start_go  = (state == IDLE) && start;
  assign busy      = (state == FETCH) || (state == DRAIN);
  // Outstanding requests plus filled entries never exceed one bank.
  assign in_flight = SUM_W'(req_cnt - rsp_cnt) + SUM_W'(fill_cnt);
  assign issue     = (state == FETCH) && (req_cnt != total) &&
                     (in_flight < SUM_W'(BANK_DEPTH));
  assign accept    = issue && !bus.master_waitrequest;
  assign rsp_fire  = (state == FETCH) && bus.master_readdatavalid;

  assign pixel_valid = busy && (drain_left != '0);
  assign xfer        = pixel_valid && pixel_ready;
  assign pixel_data  = pixel_valid ? bank[~fill_sel][drain_idx] : '0;

  assign fill_ready  = (fill_cnt == FILL_W'(BANK_DEPTH)) ||
                       ((rsp_cnt == total) && (fill_cnt != '0));
  assign drain_empty = (drain_left == '0) ||
                       ((drain_left == FILL_W'(1)) && xfer);
  assign swap        = busy && fill_ready && drain_empty;
  assign last_xfer   = (state == DRAIN) && xfer &&
                       (drain_left == FILL_W'(1)) && (fill_cnt == '0);

  assign bus.master_read    = issue;
  assign bus.master_address = addr;
  assign done_read          = (state == DONE);
  assign unused_readdata    = ^bus.master_readdata;

  flex_counter #(.WIDTH(CNT_W)) u_req_cnt (
    .clk(clk), .rst(rst), .clear(start_go), .en(accept), .count(req_cnt)
  );

  flex_counter #(.WIDTH(CNT_W)) u_rsp_cnt (
    .clk(clk), .rst(rst), .clear(start_go), .en(rsp_fire), .count(rsp_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = (total_pixels == '0) ? DONE : FETCH;
      FETCH:   if ((req_cnt == total) && (rsp_cnt == total)) state_next = DRAIN;
      DRAIN:   if (last_xfer) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bank bookkeeping; a swap retires the drain bank in the same cycle as its last transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      total      <= '0;
      fill_sel   <= 1'b0;
      fill_cnt   <= '0;
      drain_left <= '0;
      drain_idx  <= '0;
    end else if (start_go) begin
      addr       <= base_address;
      total      <= total_pixels;
      fill_sel   <= 1'b0;
      fill_cnt   <= '0;
      drain_left <= '0;
      drain_idx  <= '0;
    end else begin
      if (accept) addr <= addr + ADDR_W'(4);
      if (swap) begin
        fill_sel   <= ~fill_sel;
        drain_left <= fill_cnt;
        drain_idx  <= '0;
        fill_cnt   <= rsp_fire ? FILL_W'(1) : '0;
      end else begin
        if (rsp_fire) fill_cnt <= fill_cnt + FILL_W'(1);
        if (xfer) begin
          drain_left <= drain_left - FILL_W'(1);
          drain_idx  <= drain_idx + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_fire) begin
      if (swap) bank[~fill_sel][0] <= bus.master_readdata[PIXEL_W-1:0];
      else      bank[fill_sel][fill_cnt[IDX_W-1:0]] <= bus.master_readdata[PIXEL_W-1:0];
    end
  end

`ifdef READ_BUFFER_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           stall_count <= '0;
    else if (start_go)                                 stall_count <= '0;
    else if (bus.master_read && bus.master_waitrequest) stall_count <= sat_inc(stall_count);
  end
`endif
endmodule
